// File: rtl/operation_pkg.sv
// -----------------------------------------------------------------------------
// operation_pkg
//
// Shared definitions for the drivers of the operation_* blocks. These blocks use
// the ST/RD/RES handshake.
//   - op_state_t        : driver FSM state encoding
//   - OP_DEFAULT_BW     : default argument/result width
//   - op_state_resets() : OP_RST level that the driver shows in a given state
//   - op_state_starts() : OP_ST level that the driver shows in a given state
// -----------------------------------------------------------------------------
package operation_pkg;

  localparam int OP_DEFAULT_BW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_TERR  = 3'd5
  } op_state_t;

  // The operation is released from reset only for the START cycle and the
  // WAIT window. In all other states it is held in reset.
  function automatic logic op_state_resets(input op_state_t s);
    return !((s == ST_START) || (s == ST_WAIT));
  endfunction

  // Level-start protocol: ST is high for the whole WAIT window.
  function automatic logic op_state_starts(input op_state_t s);
    return (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/op_timeout_counter.sv
// -----------------------------------------------------------------------------
// op_timeout_counter
//
// Saturating up-counter that the operation drivers use to measure WAIT time.
// clear has priority over enable. Once the count reaches all-ones it stays
// there, so a very long wait can never wrap back to a small value.
//
// Ports:
//   CLK    in  1   clock, rising edge
//   RST    in  1   synchronous active-high reset (count -> 0)
//   clear  in  1   force count to 0 on the next edge
//   enable in  1   increment (saturating) on the next edge
//   count  out CW  current count
// -----------------------------------------------------------------------------
module op_timeout_counter #(
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {CW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/operation_driver_bw16_inc2.sv
// -----------------------------------------------------------------------------
// operation_driver_bw16_inc2
//
// Initiator for one operation instance that uses the ST/RD/RES handshake.
// The driver accepts a two-argument request and latches the arguments. It
// resets the operation and starts it, then waits for RD and captures RES. It
// holds the result until upstream acknowledges it. A cycle-count timeout turns
// an operation that never finishes into an ERR state that upstream can clear.
//
// Every output comes from a flop. No input reaches an output combinationally.
//
// Ports:
//   CLK     in  1   clock, rising edge
//   RST     in  1   synchronous active-high reset; aborts any operation
//   REQ     in  1   request, sampled only in IDLE
//   A0, A1  in  BW  arguments, latched when REQ is accepted
//   BUSY    out 1   high in every state except IDLE
//   DONE    out 1   result valid (HOLD)
//   ERR     out 1   timeout reported (TERR)
//   RESULT  out BW  captured OP_RES
//   CYCLES  out CW  WAIT cycles of the last operation (saturating)
//   ACK     in  1   consumes RESULT / clears ERR
//   OP_RST  out 1   reset to the operation
//   OP_ST   out 1   start (level) to the operation
//   OP_IN0  out BW  registered argument 0
//   OP_IN1  out BW  registered argument 1
//   OP_RD   in  1   operation result ready
//   OP_RES  in  BW  operation result
// -----------------------------------------------------------------------------
module operation_driver_bw16_inc2
  import operation_pkg::*;
#(
  parameter int BW      = OP_DEFAULT_BW,
  parameter int TIMEOUT = 1024,
  // 2**CW must exceed TIMEOUT so that the terminal count is reachable.
  parameter int CW      = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ,
  input  logic [BW-1:0] A0,
  input  logic [BW-1:0] A1,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [BW-1:0] RESULT,
  output logic [CW-1:0] CYCLES,
  input  logic          ACK,
  output logic          OP_RST,
  output logic          OP_ST,
  output logic [BW-1:0] OP_IN0,
  output logic [BW-1:0] OP_IN1,
  input  logic          OP_RD,
  input  logic [BW-1:0] OP_RES
);

  localparam bit            TO_EN   = (TIMEOUT != 0);
  // TO_LAST is meaningless when TO_EN is 0. The TO_EN guard covers that case.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  op_state_t     state_q, state_d;

  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic          err_q,    err_d;
  logic          op_rst_q, op_rst_d;
  logic          op_st_q,  op_st_d;
  logic [BW-1:0] in0_q,    in0_d;
  logic [BW-1:0] in1_q,    in1_d;
  logic [BW-1:0] result_q, result_d;
  logic [CW-1:0] cycles_q, cycles_d;

  logic          accept;
  logic          cnt_en;
  logic [CW-1:0] count;

  // WAIT-cycle counter. A request clears it. It advances once per WAIT cycle.
  op_timeout_counter #(
    .CW (CW)
  ) u_timeout_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (accept),
    .enable (cnt_en),
    .count  (count)
  );

  // Next-state logic and datapath next values.
  always_comb begin
    state_d  = state_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    result_d = result_q;
    cycles_d = cycles_q;
    accept   = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          accept  = 1'b1;
          in0_d   = A0;
          in1_d   = A1;
          state_d = ST_CLR;
        end
      end
      ST_CLR:   state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        cnt_en = 1'b1;
        // RD is checked first, so a result that arrives on the terminal
        // count cycle still counts as a success.
        if (OP_RD) begin
          result_d = OP_RES;
          cycles_d = count;
          state_d  = ST_HOLD;
        end else if (TO_EN && (count == TO_LAST)) begin
          cycles_d = count;
          state_d  = ST_TERR;
        end
      end
      ST_HOLD: if (ACK) state_d = ST_IDLE;
      ST_TERR: if (ACK) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the decode of the next state.
    // This keeps them aligned with state_q and avoids decode glitches.
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_HOLD);
    err_d    = (state_d == ST_TERR);
    op_rst_d = op_state_resets(state_d);
    op_st_d  = op_state_starts(state_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      op_rst_q <= 1'b1;
      op_st_q  <= 1'b0;
      in0_q    <= '0;
      in1_q    <= '0;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      op_rst_q <= op_rst_d;
      op_st_q  <= op_st_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERR    = err_q;
  assign RESULT = result_q;
  assign CYCLES = cycles_q;
  assign OP_RST = op_rst_q;
  assign OP_ST  = op_st_q;
  assign OP_IN0 = in0_q;
  assign OP_IN1 = in1_q;

endmodule

// File: tb/tb_operation_driver_bw16_inc2.sv
module tb_operation_driver_bw16_inc2;

  localparam int BW      = 16;
  localparam int TIMEOUT = 8;
  localparam int CW      = 16;

  logic          CLK = 1'b0;
  logic          RST, REQ, ACK, OP_RD;
  logic [BW-1:0] A0, A1, OP_RES;
  logic          BUSY, DONE, ERR, OP_RST, OP_ST;
  logic [BW-1:0] RESULT, OP_IN0, OP_IN1;
  logic [CW-1:0] CYCLES;

  int tests = 0;
  int fails = 0;

  operation_driver_bw16_inc2 #(
    .BW (BW), .TIMEOUT (TIMEOUT), .CW (CW)
  ) dut (
    .CLK (CLK), .RST (RST), .REQ (REQ), .A0 (A0), .A1 (A1),
    .BUSY (BUSY), .DONE (DONE), .ERR (ERR), .RESULT (RESULT), .CYCLES (CYCLES),
    .ACK (ACK), .OP_RST (OP_RST), .OP_ST (OP_ST), .OP_IN0 (OP_IN0), .OP_IN1 (OP_IN1),
    .OP_RD (OP_RD), .OP_RES (OP_RES)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge. Outputs are sampled and inputs are driven 1 time
  // unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; REQ = 1'b0; ACK = 1'b0; OP_RD = 1'b0;
    A0 = '0; A1 = '0; OP_RES = '0;

    // Reset then idle
    tick(); tick();
    RST = 1'b0;
    chk("rst_busy",   BUSY,   0);
    chk("rst_done",   DONE,   0);
    chk("rst_err",    ERR,    0);
    chk("rst_oprst",  OP_RST, 1);
    chk("rst_opst",   OP_ST,  0);
    chk("rst_result", RESULT, 0);
    chk("rst_cycles", CYCLES, 0);
    chk("rst_in0",    OP_IN0, 0);
    tick();
    chk("idle_busy",  BUSY,   0);
    chk("idle_oprst", OP_RST, 1);

    // Basic op: RD arrives on the 3rd WAIT cycle
    A0 = 16'h0000; A1 = 16'h0001; REQ = 1'b1;
    tick();                                   // CLR
    REQ = 1'b0;
    chk("clr_busy",  BUSY,   1);
    chk("clr_oprst", OP_RST, 1);
    chk("clr_opst",  OP_ST,  0);
    chk("clr_in0",   OP_IN0, 16'h0000);
    chk("clr_in1",   OP_IN1, 16'h0001);
    tick();                                   // START
    chk("start_oprst", OP_RST, 0);
    chk("start_opst",  OP_ST,  0);
    tick();                                   // WAIT1
    chk("w1_opst",  OP_ST,  1);
    chk("w1_oprst", OP_RST, 0);
    // REQ and ACK outside their states must be ignored
    REQ = 1'b1; ACK = 1'b1; A0 = 16'hDEAD; A1 = 16'hBEEF;
    tick();                                   // WAIT2
    REQ = 1'b0; ACK = 1'b0;
    chk("w2_opst",  OP_ST,  1);
    chk("w2_busy",  BUSY,   1);
    chk("w2_in0",   OP_IN0, 16'h0000);
    chk("w2_in1",   OP_IN1, 16'h0001);
    tick();                                   // WAIT3
    chk("w3_opst",  OP_ST,  1);
    chk("w3_done",  DONE,   0);
    OP_RD = 1'b1; OP_RES = 16'h0003;
    tick();                                   // HOLD
    OP_RD = 1'b0; OP_RES = 16'h7777;
    chk("basic_done",   DONE,   1);
    chk("basic_result", RESULT, 16'h0003);
    chk("basic_cycles", CYCLES, 2);
    chk("basic_opst",   OP_ST,  0);
    chk("basic_oprst",  OP_RST, 1);
    tick(); tick();                           // hold without ACK
    chk("hold_done",   DONE,   1);
    chk("hold_result", RESULT, 16'h0003);
    ACK = 1'b1;
    tick();                                   // IDLE
    ACK = 1'b0;
    chk("ack_done", DONE, 0);
    chk("ack_busy", BUSY, 0);

    // Immediate ready: DONE on the 4th edge after REQ
    A0 = 16'h1234; A1 = 16'h5678; REQ = 1'b1;
    tick();                                   // edge 1: CLR
    REQ = 1'b0;
    tick();                                   // edge 2: START
    OP_RD = 1'b1; OP_RES = 16'hFFFF;
    tick();                                   // edge 3: WAIT1
    chk("imm_done_e3", DONE, 0);
    tick();                                   // edge 4: HOLD
    OP_RD = 1'b0;
    chk("imm_done",   DONE,   1);
    chk("imm_result", RESULT, 16'hFFFF);
    chk("imm_cycles", CYCLES, 0);
    chk("imm_in0",    OP_IN0, 16'h1234);
    ACK = 1'b1; tick(); ACK = 1'b0;

    // Timeout: no RD, TERR after 8 WAIT cycles
    A0 = 16'hAAAA; A1 = 16'h5555; REQ = 1'b1;
    tick(); REQ = 1'b0;                       // CLR
    tick();                                   // START
    tick();                                   // WAIT1
    for (int i = 0; i < 7; i++) tick();       // WAIT8
    chk("to_err_w8",  ERR,   0);
    chk("to_opst_w8", OP_ST, 1);
    tick();                                   // TERR
    chk("to_err",    ERR,    1);
    chk("to_done",   DONE,   0);
    chk("to_cycles", CYCLES, 7);
    chk("to_opst",   OP_ST,  0);
    chk("to_oprst",  OP_RST, 1);
    chk("to_result", RESULT, 16'hFFFF);
    tick();
    chk("to_err_hold", ERR, 1);
    ACK = 1'b1; tick(); ACK = 1'b0;           // IDLE
    chk("to_ack_err",  ERR,  0);
    chk("to_ack_busy", BUSY, 0);

    // RD on the terminal-count cycle wins over the timeout
    A0 = 16'h0101; A1 = 16'h0202; REQ = 1'b1;
    tick(); REQ = 1'b0;                       // CLR
    tick();                                   // START
    tick();                                   // WAIT1
    for (int i = 0; i < 7; i++) tick();       // WAIT8, count = 7
    OP_RD = 1'b1; OP_RES = 16'h00C5;
    tick();                                   // HOLD
    OP_RD = 1'b0;
    chk("tie_done",   DONE,   1);
    chk("tie_err",    ERR,    0);
    chk("tie_result", RESULT, 16'h00C5);
    chk("tie_cycles", CYCLES, 7);
    ACK = 1'b1; tick(); ACK = 1'b0;

    // Mid-op reset during WAIT
    A0 = 16'h0F0F; A1 = 16'hF0F0; REQ = 1'b1;
    tick(); REQ = 1'b0;                       // CLR
    tick(); tick(); tick();                   // WAIT2
    chk("mid_opst_pre", OP_ST, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_opst",   OP_ST,  0);
    chk("mid_busy",   BUSY,   0);
    chk("mid_done",   DONE,   0);
    chk("mid_oprst",  OP_RST, 1);
    chk("mid_result", RESULT, 0);
    tick();
    chk("mid_idle_busy", BUSY, 0);

    // Back-to-back: REQ held across ACK
    A0 = 16'h0011; A1 = 16'h0022; REQ = 1'b1;
    tick();                                   // CLR
    tick();                                   // START
    tick();                                   // WAIT1
    OP_RD = 1'b1; OP_RES = 16'h0033;
    tick();                                   // HOLD
    OP_RD = 1'b0;
    chk("b2b1_done",   DONE,   1);
    chk("b2b1_result", RESULT, 16'h0033);
    chk("b2b1_in0",    OP_IN0, 16'h0011);
    A0 = 16'h0044; A1 = 16'h0055; ACK = 1'b1;
    tick();                                   // IDLE
    ACK = 1'b0;
    chk("b2b_idle_busy", BUSY, 0);
    chk("b2b_idle_done", DONE, 0);
    tick();                                   // CLR, new request accepted
    REQ = 1'b0;
    chk("b2b2_busy", BUSY,   1);
    chk("b2b2_in0",  OP_IN0, 16'h0044);
    chk("b2b2_in1",  OP_IN1, 16'h0055);
    tick();                                   // START
    tick();                                   // WAIT1
    chk("b2b2_w_in0", OP_IN0, 16'h0044);
    chk("b2b2_w_in1", OP_IN1, 16'h0055);
    OP_RD = 1'b1; OP_RES = 16'h0099;
    tick();                                   // HOLD
    OP_RD = 1'b0;
    chk("b2b2_done",   DONE,   1);
    chk("b2b2_result", RESULT, 16'h0099);
    chk("b2b2_cycles", CYCLES, 0);
    ACK = 1'b1; tick(); ACK = 1'b0;
    chk("end_busy", BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operation_driver_bw16_inc2.md
Name: operation_driver_bw16_inc2

Overview:
Initiator for the ST/RD/RES handshake used by the operation_* blocks. It takes a two-argument request from upstream and latches the arguments. It then resets and starts one downstream operation instance, waits for RD, captures RES and holds the result until upstream acknowledges it. A cycle-count timeout catches operations that never assert RD, e.g. non-terminating iteration.

Parameters:
BW, 16, data bit width of arguments and result
TIMEOUT, 1024, max cycles in WAIT before error; 0 disables the timeout
CW, 16, width of timeout/cycle counter; must satisfy 2**CW > TIMEOUT

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
REQ  in  1  upstream request; sampled only in IDLE
A0  in  BW  argument 0, latched when REQ is accepted
A1  in  BW  argument 1, latched when REQ is accepted
BUSY  out  1  high in every state except IDLE
DONE  out  1  high while HOLD (result valid)
ERR  out  1  high while TERR (timeout)
RESULT  out  BW  captured OP_RES; valid while DONE
CYCLES  out  CW  cycles spent in WAIT for the last operation, saturating
ACK  in  1  upstream consumes RESULT or clears ERR
OP_RST  out  1  reset to the operation instance
OP_ST  out  1  start to the operation instance
OP_IN0  out  BW  registered argument 0 to the operation
OP_IN1  out  BW  registered argument 1 to the operation
OP_RD  in  1  operation result ready
OP_RES  in  BW  operation result

Behaviour:
- Reset values (RST=1 at a clock edge): state IDLE. BUSY=0, DONE=0, ERR=0, RESULT=0, CYCLES=0, OP_ST=0, OP_IN0=0, OP_IN1=0, OP_RST=1.
- RST mid-operation aborts immediately: OP_ST drops on the same edge, OP_RST=1, and no result is captured.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - OP_RST=1, OP_ST=0.
  - REQ=1 → latch A0/A1 into OP_IN0/OP_IN1, clear the counter, go to CLR.
- CLR (1 cycle):
  - OP_RST=1 so the operation is freshly reset with stable inputs.
  - Next state is START.
- START (1 cycle):
  - OP_RST=0, OP_ST=0; gives the operation one clean cycle out of reset.
  - Next state is WAIT.
- WAIT:
  - OP_RST=0, OP_ST=1; OP_ST stays high for the whole wait (level-start protocol).
  - Each cycle the counter increments, saturating at all-ones.
  - OP_RD=1 → RESULT<=OP_RES, CYCLES<=counter, go to HOLD.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1 → CYCLES<=counter, go to TERR.
  - OP_RD takes priority over a timeout in the same cycle.
- HOLD:
  - OP_ST=0, OP_RST=1, DONE=1; RESULT stays stable.
  - ACK=1 → go to IDLE; DONE falls on the next edge.
- TERR:
  - OP_ST=0, OP_RST=1, ERR=1; RESULT keeps its previous value.
  - ACK=1 → go to IDLE.
- ACK outside HOLD/TERR is ignored. REQ outside IDLE is ignored and is not queued.
- If REQ is held high across an ACK, a new request is accepted in the first IDLE cycle, so back-to-back throughput is 4+N cycles per operation.
- Latency from REQ accepted to DONE=1 is N+3 edges, where N is the number of WAIT cycles including the cycle in which OP_RD is sampled.
  - Edge 1: IDLE→CLR. Edge 2: CLR→START. Edge 3: START→WAIT.
  - OP_RD is sampled from the first WAIT cycle onward, so an operation that asserts RD the cycle after ST rises gives CYCLES=0.
- OP_IN0/OP_IN1 change only on REQ acceptance and stay constant from CLR through HOLD.

Decomposition:
- Shared package (operation_pkg): state encoding localparams (IDLE=0, CLR=1, START=2, WAIT=3, HOLD=4, TERR=5) and the default BW.
- One sub-module: op_timeout_counter (CLK, RST, clear, enable, count, saturating), reusable by other operation drivers.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, release → BUSY=0, DONE=0, ERR=0, OP_RST=1, OP_ST=0, RESULT=0.
- Basic op: A0=0, A1=1, REQ pulse; stub operation asserts OP_RD with OP_RES=16'h0003 on the 3rd WAIT cycle → DONE=1 with RESULT=3 and CYCLES=2; OP_ST high for exactly 3 cycles; DONE held until ACK.
- Immediate ready: stub asserts RD on the first WAIT cycle with OP_RES=16'hFFFF → CYCLES=0, RESULT=FFFF, DONE after 4 edges from REQ.
- Timeout: TIMEOUT=8, stub never asserts RD → ERR=1 after 8 WAIT cycles, CYCLES=7, OP_ST=0; ACK → IDLE; RESULT unchanged from the prior op.
- Same-cycle RD and timeout: stub asserts RD exactly on the cycle where the counter equals TIMEOUT-1 → DONE=1, ERR=0.
- Mid-op reset and back-to-back: RST during WAIT → next cycle OP_ST=0, BUSY=0, DONE=0. Separately, REQ held high with ACK in HOLD → second op starts with the new A0/A1, and OP_IN0/OP_IN1 never change during WAIT.
